// File: rtl/pwr_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : pwr_seq_if
// Description : Request/status bundle between the panel power sequencer and
//               its controller.
//               Requests (to sequencer) : on_req, off_req, fault_clr (1-cycle
//                                         pulses), fault (asynchronous level).
//               Status (from sequencer) : en_p14v, en_n14v, en_gvddp,
//                                         en_gvddn, pwr_ready, busy,
//                                         fault_sts, dis_lock.
//               slave modport  = sequencer side
//               master modport = controller side
// Revision    : 1.0 - initial release
// ============================================================================
interface pwr_seq_if;
  logic on_req;
  logic off_req;
  logic fault;
  logic fault_clr;
  logic en_p14v;
  logic en_n14v;
  logic en_gvddp;
  logic en_gvddn;
  logic pwr_ready;
  logic busy;
  logic fault_sts;
  logic dis_lock;

  modport slave (
    input  on_req, off_req, fault, fault_clr,
    output en_p14v, en_n14v, en_gvddp, en_gvddn,
    output pwr_ready, busy, fault_sts, dis_lock
  );

  modport master (
    output on_req, off_req, fault, fault_clr,
    input  en_p14v, en_n14v, en_gvddp, en_gvddn,
    input  pwr_ready, busy, fault_sts, dis_lock
  );
endinterface
`default_nettype wire

// File: rtl/pwr_seq.sv
`default_nettype none
// ============================================================================
// Module      : pwr_seq
// Description : Panel power-rail sequencer. Enables p14v -> n14v -> gvddp ->
//               gvddn spaced T = STEP_MS*CNT1MS*CNT1US clocks apart, drops
//               them in reverse order with the same spacing, and latches a
//               regulator fault that kills all rails at once.
//   Ports     : clk   - system clock
//               rst_n - asynchronous reset, active low
//               bus   - pwr_seq_if.slave request/status bundle
// Revision    : 1.0 - initial release
// ============================================================================
module pwr_seq #(
  parameter int CNT1US  = 81,
  parameter int CNT1MS  = 1000,
  parameter int STEP_MS = 10
) (
  input  logic      clk,
  input  logic      rst_n,
  pwr_seq_if.slave  bus
);

  localparam int c_US_W   = (CNT1US  > 1) ? $clog2(CNT1US)  : 1;
  localparam int c_MS_W   = (CNT1MS  > 1) ? $clog2(CNT1MS)  : 1;
  localparam int c_STEP_W = (STEP_MS > 1) ? $clog2(STEP_MS) : 1;

  localparam logic [c_US_W-1:0]   c_US_LAST   = c_US_W'(CNT1US - 1);
  localparam logic [c_MS_W-1:0]   c_MS_LAST   = c_MS_W'(CNT1MS - 1);
  localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(STEP_MS - 1);

  // DNk keeps rails 1..k-1 on while waiting to drop rail k-1.
  typedef enum logic [3:0] {
    S_OFF   = 4'd0,
    S_UP1   = 4'd1,
    S_UP2   = 4'd2,
    S_UP3   = 4'd3,
    S_UP4   = 4'd4,
    S_READY = 4'd5,
    S_DN4   = 4'd6,
    S_DN3   = 4'd7,
    S_DN2   = 4'd8,
    S_DN1   = 4'd9,
    S_FAULT = 4'd10
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_fault_meta;
  logic                 r_fault_s;
  logic [c_US_W-1:0]    r_us;
  logic [c_MS_W-1:0]    r_ms;
  logic [c_STEP_W-1:0]  r_step;
  logic                 w_us_last;
  logic                 w_ms_last;
  logic                 w_step_done;

  // Rail enables: bit0 p14v, bit1 n14v, bit2 gvddp, bit3 gvddn.
  logic [3:0]           r_rails;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_fault_sts;
  logic                 r_dis_lock;
  logic [3:0]           w_rails;
  logic                 w_ready;
  logic                 w_busy;
  logic                 w_fault_sts;

  assign w_us_last   = (r_us == c_US_LAST);
  assign w_ms_last   = (r_ms == c_MS_LAST);
  // Timer counts 0..T-1 from the entry edge, so the transition lands exactly
  // T edges after entry.
  assign w_step_done = w_us_last && w_ms_last && (r_step == c_STEP_LAST);

  always_comb begin
    w_state_next = r_state;
    w_rails      = 4'b0000;
    w_ready      = 1'b0;
    w_busy       = 1'b0;
    w_fault_sts  = 1'b0;

    if (r_fault_s) begin
      w_state_next = S_FAULT;
    end else begin
      case (r_state)
        S_OFF:   if (!bus.off_req && bus.on_req) w_state_next = S_UP1;
        S_UP1:   if (bus.off_req) w_state_next = S_OFF;
                 else if (w_step_done) w_state_next = S_UP2;
        S_UP2:   if (bus.off_req) w_state_next = S_DN2;
                 else if (w_step_done) w_state_next = S_UP3;
        S_UP3:   if (bus.off_req) w_state_next = S_DN3;
                 else if (w_step_done) w_state_next = S_UP4;
        S_UP4:   if (bus.off_req) w_state_next = S_DN4;
                 else if (w_step_done) w_state_next = S_READY;
        S_READY: if (bus.off_req) w_state_next = S_DN4;
        S_DN4:   if (w_step_done) w_state_next = S_DN3;
        S_DN3:   if (w_step_done) w_state_next = S_DN2;
        S_DN2:   if (w_step_done) w_state_next = S_OFF;
        S_DN1:   if (w_step_done) w_state_next = S_OFF;
        S_FAULT: if (bus.fault_clr) w_state_next = S_OFF;
        default: w_state_next = S_OFF;
      endcase
    end

    // Outputs are decoded from the next state and registered, so they
    // change on the same edge as the state.
    case (w_state_next)
      S_UP1:   begin w_rails = 4'b0001; w_busy = 1'b1; end
      S_UP2:   begin w_rails = 4'b0011; w_busy = 1'b1; end
      S_UP3:   begin w_rails = 4'b0111; w_busy = 1'b1; end
      S_UP4:   begin w_rails = 4'b1111; w_busy = 1'b1; end
      S_READY: begin w_rails = 4'b1111; w_ready = 1'b1; end
      S_DN4:   begin w_rails = 4'b0111; w_busy = 1'b1; end
      S_DN3:   begin w_rails = 4'b0011; w_busy = 1'b1; end
      S_DN2:   begin w_rails = 4'b0001; w_busy = 1'b1; end
      S_DN1:   begin w_rails = 4'b0000; w_busy = 1'b1; end
      S_FAULT: w_fault_sts = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_OFF;
      r_fault_meta <= 1'b0;
      r_fault_s    <= 1'b0;
      r_us         <= '0;
      r_ms         <= '0;
      r_step       <= '0;
      r_rails      <= 4'b0000;
      r_ready      <= 1'b0;
      r_busy       <= 1'b0;
      r_fault_sts  <= 1'b0;
      r_dis_lock   <= 1'b0;
    end else begin
      r_fault_meta <= bus.fault;
      r_fault_s    <= r_fault_meta;
      r_state      <= w_state_next;
      r_rails      <= w_rails;
      r_ready      <= w_ready;
      r_busy       <= w_busy;
      r_fault_sts  <= w_fault_sts;
      r_dis_lock   <= w_busy | w_fault_sts;

      if (w_state_next != r_state) begin
        r_us   <= '0;
        r_ms   <= '0;
        r_step <= '0;
      end else if (w_us_last) begin
        r_us <= '0;
        if (w_ms_last) begin
          r_ms   <= '0;
          r_step <= (r_step == c_STEP_LAST) ? '0 : r_step + c_STEP_W'(1);
        end else begin
          r_ms <= r_ms + c_MS_W'(1);
        end
      end else begin
        r_us <= r_us + c_US_W'(1);
      end
    end
  end

  assign bus.en_p14v   = r_rails[0];
  assign bus.en_n14v   = r_rails[1];
  assign bus.en_gvddp  = r_rails[2];
  assign bus.en_gvddn  = r_rails[3];
  assign bus.pwr_ready = r_ready;
  assign bus.busy      = r_busy;
  assign bus.fault_sts = r_fault_sts;
  assign bus.dis_lock  = r_dis_lock;

endmodule
`default_nettype wire
